// File: rtl/ps2_pkg.sv
// ps2_pkg: shared types and constants for the PS/2 scan-code receiver.
//   ps2_state_t    - frame receiver states (IDLE, DATA, PARITY, STOP)
//   PS2_PREFIX_EXT - extended-key prefix byte
//   PS2_PREFIX_BRK - break (key release) prefix byte
package ps2_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } ps2_state_t;

  localparam logic [7:0] PS2_PREFIX_EXT = 8'hE0;
  localparam logic [7:0] PS2_PREFIX_BRK = 8'hF0;

endpackage

// File: rtl/ps2_edge_sync.sv
// ps2_edge_sync: synchronizes the raw PS/2 pins into the clk domain and
// detects falling edges of the PS/2 clock.
//   i_clk      system clock
//   i_rst_n    asynchronous active-low reset (synchronizers reset to idle-high)
//   i_ps2_clk  raw PS/2 clock pin
//   i_ps2_dat  raw PS/2 data pin
//   o_dat_s    synchronized data, valid for sampling when o_fall is high
//   o_fall     one-cycle strobe: synchronized PS/2 clock went 1 -> 0
module ps2_edge_sync (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_ps2_clk,
  input  logic i_ps2_dat,
  output logic o_dat_s,
  output logic o_fall
);

  // [1:0] is the 2-flop synchronizer, [2] holds the previous synced value
  logic [2:0] r_clk_sync;
  logic [1:0] r_dat_sync;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_clk_sync <= '1;
      r_dat_sync <= '1;
    end else begin
      r_clk_sync <= {r_clk_sync[1:0], i_ps2_clk};
      r_dat_sync <= {r_dat_sync[0], i_ps2_dat};
    end
  end

  assign o_dat_s = r_dat_sync[1];
  assign o_fall  = r_clk_sync[2] & ~r_clk_sync[1];

endmodule

// File: rtl/ps2_scan_receiver.sv
// ps2_scan_receiver: PS/2 keyboard frame receiver with make/break/extended
// qualification and a two-code history for the hex displays.
//   TIMEOUT_CYCLES  clk cycles without a PS/2 falling edge before an
//                   in-progress frame is abandoned
//   i_clk           system clock
//   i_resetn        asynchronous active-low reset
//   i_ps2_clk       PS/2 clock pin (asynchronous, idle high)
//   i_ps2_dat       PS/2 data pin (asynchronous, idle high)
//   o_code          last accepted non-prefix scan code
//   o_code_valid    one-cycle pulse when code/release/extended update
//   o_release       delivered code was preceded by 0xF0
//   o_extended      delivered code was preceded by 0xE0
//   o_frame_err     one-cycle pulse on bad start/parity/stop or timeout
//   o_hex_digits    {previous code, latest code}, nibble [3:0] -> HEX0
module ps2_scan_receiver
  import ps2_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic        i_clk,
  input  logic        i_resetn,
  input  logic        i_ps2_clk,
  input  logic        i_ps2_dat,
  output logic [7:0]  o_code,
  output logic        o_code_valid,
  output logic        o_release,
  output logic        o_extended,
  output logic        o_frame_err,
  output logic [15:0] o_hex_digits
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);

  logic w_dat_s;
  logic w_fall;

  ps2_state_t    r_state;
  logic [2:0]    r_bit_cnt;
  logic [7:0]    r_sh;
  logic          r_par;
  logic [CW-1:0] r_to_cnt;
  logic          r_ext_pend;
  logic          r_brk_pend;
  logic [7:0]    r_code;
  logic          r_code_valid;
  logic          r_release;
  logic          r_extended;
  logic          r_frame_err;
  logic [15:0]   r_hex_digits;

  ps2_edge_sync u_edge_sync (
    .i_clk     (i_clk),
    .i_rst_n   (i_resetn),
    .i_ps2_clk (i_ps2_clk),
    .i_ps2_dat (i_ps2_dat),
    .o_dat_s   (w_dat_s),
    .o_fall    (w_fall)
  );

  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      r_state      <= ST_IDLE;
      r_bit_cnt    <= '0;
      r_sh         <= '0;
      r_par        <= 1'b0;
      r_to_cnt     <= '0;
      r_ext_pend   <= 1'b0;
      r_brk_pend   <= 1'b0;
      r_code       <= '0;
      r_code_valid <= 1'b0;
      r_release    <= 1'b0;
      r_extended   <= 1'b0;
      r_frame_err  <= 1'b0;
      r_hex_digits <= '0;
    end else begin
      r_code_valid <= 1'b0;
      r_frame_err  <= 1'b0;
      // An edge takes priority over a coinciding timeout expiry
      if (w_fall) begin
        r_to_cnt <= '0;
        unique case (r_state)
          ST_IDLE: begin
            // A high start bit is line noise, not a frame
            if (!w_dat_s) begin
              r_state   <= ST_DATA;
              r_bit_cnt <= '0;
            end
          end
          ST_DATA: begin
            r_sh      <= {w_dat_s, r_sh[7:1]};
            r_bit_cnt <= r_bit_cnt + 3'd1;
            if (r_bit_cnt == 3'd7) r_state <= ST_PARITY;
          end
          ST_PARITY: begin
            r_par   <= w_dat_s;
            r_state <= ST_STOP;
          end
          ST_STOP: begin
            r_state <= ST_IDLE;
            if (w_dat_s && (^{r_sh, r_par})) begin
              if (r_sh == PS2_PREFIX_EXT) begin
                r_ext_pend <= 1'b1;
              end else if (r_sh == PS2_PREFIX_BRK) begin
                r_brk_pend <= 1'b1;
              end else begin
                r_code       <= r_sh;
                r_release    <= r_brk_pend;
                r_extended   <= r_ext_pend;
                r_hex_digits <= {r_hex_digits[7:0], r_sh};
                r_code_valid <= 1'b1;
                r_ext_pend   <= 1'b0;
                r_brk_pend   <= 1'b0;
              end
            end else begin
              r_frame_err <= 1'b1;
              r_ext_pend  <= 1'b0;
              r_brk_pend  <= 1'b0;
            end
          end
          default: r_state <= ST_IDLE;
        endcase
      end else if (r_state == ST_IDLE) begin
        r_to_cnt <= '0;
      end else if (r_to_cnt == TO_LAST) begin
        r_to_cnt    <= '0;
        r_state     <= ST_IDLE;
        r_frame_err <= 1'b1;
        r_ext_pend  <= 1'b0;
        r_brk_pend  <= 1'b0;
      end else begin
        r_to_cnt <= r_to_cnt + CW'(1);
      end
    end
  end

  assign o_code       = r_code;
  assign o_code_valid = r_code_valid;
  assign o_release    = r_release;
  assign o_extended   = r_extended;
  assign o_frame_err  = r_frame_err;
  assign o_hex_digits = r_hex_digits;

endmodule

// File: tb/tb_ps2_scan_receiver.sv
module tb_ps2_scan_receiver;

  // Short timeout and fast PS/2 clock keep the run to a few tens of
  // thousands of cycles; every bit period stays well below the timeout.
  localparam int unsigned TO = 300;

  logic        clk = 1'b0;
  logic        resetn = 1'b1;
  logic        ps2_clk = 1'b1;
  logic        ps2_dat = 1'b1;
  logic [7:0]  o_code;
  logic        o_code_valid;
  logic        o_release;
  logic        o_extended;
  logic        o_frame_err;
  logic [15:0] o_hex_digits;

  ps2_scan_receiver #(.TIMEOUT_CYCLES(TO)) dut (
    .i_clk        (clk),
    .i_resetn     (resetn),
    .i_ps2_clk    (ps2_clk),
    .i_ps2_dat    (ps2_dat),
    .o_code       (o_code),
    .o_code_valid (o_code_valid),
    .o_release    (o_release),
    .o_extended   (o_extended),
    .o_frame_err  (o_frame_err),
    .o_hex_digits (o_hex_digits)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    bit          is_err;
    logic [7:0]  code;
    bit          rel;
    bit          ext;
    logic [15:0] hex;
    int unsigned due;
  } ev_t;

  ev_t evq[$];

  // Stimulus-side model: pending prefixes and display history
  bit          mp_ext = 0;
  bit          mp_brk = 0;
  logic [15:0] mhex   = '0;
  int unsigned last_fall_cyc = 0;

  // Compare-side view of what the held outputs must currently be
  logic [7:0]  m_code = '0;
  bit          m_rel  = 0;
  bit          m_ext  = 0;
  logic [15:0] m_hex  = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (!resetn) begin
      m_code = '0; m_rel = 0; m_ext = 0; m_hex = '0;
      chk("reset_outputs",
          {4'b0, o_code, o_code_valid, o_frame_err, o_release, o_extended, o_hex_digits}, 32'h0);
    end else begin
      chk("pulse_overlap", {31'b0, o_code_valid & o_frame_err}, 32'h0);
      if (o_code_valid || o_frame_err) begin
        if (evq.size() == 0) begin
          chk("unexpected_pulse", {30'b0, o_code_valid, o_frame_err}, 32'h0);
        end else begin
          ev_t e;
          e = evq.pop_front();
          chk("pulse_kind", {30'b0, o_code_valid, o_frame_err}, e.is_err ? 32'h1 : 32'h2);
          chk("pulse_cycle", cyc, e.due);
          if (!e.is_err) begin
            m_code = e.code; m_rel = e.rel; m_ext = e.ext; m_hex = e.hex;
          end
        end
      end
      chk("held_outputs", {6'b0, o_code, o_release, o_extended, o_hex_digits},
          {6'b0, m_code, m_rel, m_ext, m_hex});
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic ps2_bit(input bit b, input int hp);
    ps2_dat = b;
    tick(hp);
    ps2_clk = 1'b0;
    last_fall_cyc = cyc;
    tick(hp);
    ps2_clk = 1'b1;
  endtask

  task automatic drain_check();
    tick(12);
    chk("queue_drained", evq.size(), 32'h0);
    evq.delete();
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop, input int hp);
    bit p;
    ev_t e;
    p = (~^b) ^ bad_par;
    ps2_bit(1'b0, hp);
    for (int i = 0; i < 8; i++) ps2_bit(b[i], hp);
    ps2_bit(p, hp);
    ps2_dat = !bad_stop;
    tick(hp);
    ps2_clk = 1'b0;
    e.due = cyc + 3;
    e.code = b; e.rel = 0; e.ext = 0; e.hex = mhex; e.is_err = 0;
    if (bad_par || bad_stop) begin
      e.is_err = 1;
      evq.push_back(e);
      mp_ext = 0; mp_brk = 0;
    end else if (b == 8'hE0) begin
      mp_ext = 1;
    end else if (b == 8'hF0) begin
      mp_brk = 1;
    end else begin
      mhex = {mhex[7:0], b};
      e.rel = mp_brk; e.ext = mp_ext; e.hex = mhex;
      evq.push_back(e);
      mp_ext = 0; mp_brk = 0;
    end
    tick(hp);
    ps2_clk = 1'b1;
    ps2_dat = 1'b1;
    drain_check();
    tick($urandom_range(5, 30));
  endtask

  task automatic send_timeout(input int hp);
    ev_t e;
    ps2_bit(1'b0, hp);
    for (int i = 0; i < 4; i++) ps2_bit(1'(i), hp);
    e.is_err = 1; e.code = '0; e.rel = 0; e.ext = 0; e.hex = mhex;
    e.due = last_fall_cyc + TO + 3;
    evq.push_back(e);
    mp_ext = 0; mp_brk = 0;
    ps2_dat = 1'b1;
    tick(TO + 20);
    drain_check();
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int hp;
    #1 resetn = 1'b0;
    tick(5);
    resetn = 1'b1;
    tick(10);

    // Good frame
    send_frame(8'h1C, 0, 0, 20);
    chk("lit_good_code", {24'b0, o_code}, 32'h1C);
    chk("lit_good_hex", {16'b0, o_hex_digits}, 32'h001C);
    chk("lit_good_flags", {30'b0, o_release, o_extended}, 32'h0);

    // Break
    send_frame(8'hF0, 0, 0, 20);
    send_frame(8'h1C, 0, 0, 20);
    chk("lit_brk_hex", {16'b0, o_hex_digits}, 32'h1C1C);
    chk("lit_brk_flags", {30'b0, o_release, o_extended}, 32'h2);

    // Extended break, then plain
    send_frame(8'hE0, 0, 0, 17);
    send_frame(8'hF0, 0, 0, 17);
    send_frame(8'h75, 0, 0, 17);
    chk("lit_extbrk_code", {24'b0, o_code}, 32'h75);
    chk("lit_extbrk_flags", {30'b0, o_release, o_extended}, 32'h3);
    send_frame(8'h75, 0, 0, 17);
    chk("lit_plain_flags", {30'b0, o_release, o_extended}, 32'h0);
    chk("lit_plain_hex", {16'b0, o_hex_digits}, 32'h7575);

    // Bad parity, bad stop: history untouched
    send_frame(8'h1C, 1, 0, 20);
    send_frame(8'h32, 0, 1, 20);
    chk("lit_err_hex", {16'b0, o_hex_digits}, 32'h7575);

    // Prefix lost to an error does not qualify the next code
    send_frame(8'hF0, 0, 0, 20);
    send_frame(8'h11, 1, 0, 20);
    send_frame(8'h22, 0, 0, 20);
    chk("lit_errclr_flags", {30'b0, o_release, o_extended}, 32'h0);

    // Noise edge in idle with data high
    ps2_bit(1'b1, 20);
    drain_check();

    // Timeout then recovery
    send_timeout(20);
    send_frame(8'h32, 0, 0, 20);
    chk("lit_to_code", {24'b0, o_code}, 32'h32);

    // Randomized traffic
    for (int n = 0; n < 25; n++) begin
      int sel;
      logic [7:0] b;
      sel = $urandom_range(0, 9);
      b = (sel == 0) ? 8'hE0 : (sel == 1) ? 8'hF0 : 8'($urandom);
      hp = $urandom_range(10, 30);
      sel = $urandom_range(0, 19);
      if (sel == 0) send_timeout(hp);
      else if (sel == 1) begin ps2_bit(1'b1, hp); drain_check(); end
      else send_frame(b, sel == 2 || sel == 3, sel == 4, hp);
    end

    // Reset mid-frame during bit 5
    ps2_bit(1'b0, 20);
    for (int i = 0; i < 5; i++) ps2_bit(1'b1, 20);
    ps2_dat = 1'b0;
    tick(7);
    resetn = 1'b0;
    mp_ext = 0; mp_brk = 0; mhex = '0;
    evq.delete();
    tick(2);
    chk("lit_rst_outputs", {16'b0, o_hex_digits} | {24'b0, o_code}, 32'h0);
    ps2_dat = 1'b1;
    tick(5);
    resetn = 1'b1;
    tick(10);
    send_frame(8'h45, 0, 0, 20);
    chk("lit_rst_code", {24'b0, o_code}, 32'h45);
    chk("lit_rst_hex", {16'b0, o_hex_digits}, 32'h0045);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
